// File: rtl/tm1638_spi.sv
// TM1638 serial transmit engine: STB/CLK/DIO, LSB first, one or two bytes per word.
// Define TM1638_SPI_DIAG_EN to drive the diag outputs; otherwise they are tied to 0.
module tm1638_spi #(
  parameter int CYCLES = 4
) (
  input  logic        i_Rst,
  input  logic        i_Clk,
  output logic        o_Busy,
  input  logic        i_Data_Ready,
  input  logic [17:0] i_Data,
  output logic        o_SPI_Stb,
  output logic        o_SPI_Clk,
  output logic        o_SPI_Dio,
  output logic [2:0]  o_Diag_State,
  output logic [17:0] o_Diag_Data,
  output logic [3:0]  o_Diag_Addr
);

  typedef struct packed {
    logic       cont;
    logic       mode;
    logic [7:0] byte1;
    logic [7:0] byte0;
  } word_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    CLK_LO = 3'd2,
    CLK_HI = 3'd3,
    GAP    = 3'd4,
    STOP   = 3'd5
  } state_t;

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(CYCLES - 1);

  state_t      state;
  word_t       word;
  logic [CW-1:0] cnt;
  logic [2:0]  bit_idx;
  logic        byte_sel;
  logic        stb, sclk, dio, busy;

  logic [7:0]  cur_byte;
  logic [2:0]  nxt_idx;
  logic        cnt_done;

  assign cur_byte = byte_sel ? word.byte1 : word.byte0;
  assign nxt_idx  = bit_idx + 3'd1;
  assign cnt_done = (cnt == '0);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state    <= IDLE;
      word     <= '0;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_sel <= 1'b0;
      stb      <= 1'b1;
      sclk     <= 1'b1;
      dio      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_Data_Ready) begin
            word     <= word_t'(i_Data);
            busy     <= 1'b1;
            bit_idx  <= '0;
            byte_sel <= 1'b0;
            cnt      <= CNT_LOAD;
            // An open frame (previous word had CONT=1) goes straight to the first bit.
            if (stb) begin
              state <= START;
              stb   <= 1'b0;
              sclk  <= 1'b1;
            end else begin
              state <= CLK_LO;
              sclk  <= 1'b0;
              dio   <= i_Data[0];
            end
          end
        end
        START, GAP: begin
          if (cnt_done) begin
            state <= CLK_LO;
            cnt   <= CNT_LOAD;
            sclk  <= 1'b0;
            dio   <= cur_byte[0];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        CLK_LO: begin
          if (cnt_done) begin
            state <= CLK_HI;
            cnt   <= CNT_LOAD;
            sclk  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        CLK_HI: begin
          if (!cnt_done) begin
            cnt <= cnt - 1'b1;
          end else if (bit_idx != 3'd7) begin
            state   <= CLK_LO;
            cnt     <= CNT_LOAD;
            bit_idx <= nxt_idx;
            sclk    <= 1'b0;
            dio     <= cur_byte[nxt_idx];
          end else if (!byte_sel && word.mode) begin
            state    <= GAP;
            cnt      <= CNT_LOAD;
            bit_idx  <= '0;
            byte_sel <= 1'b1;
          end else if (word.cont) begin
            // Leave STB low so the next word continues this frame.
            state <= IDLE;
            busy  <= 1'b0;
            dio   <= 1'b1;
          end else begin
            state <= STOP;
            cnt   <= CNT_LOAD;
            dio   <= 1'b1;
          end
        end
        STOP: begin
          if (cnt_done) begin
            state <= IDLE;
            stb   <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          stb   <= 1'b1;
          sclk  <= 1'b1;
          dio   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_Busy    = busy;
  assign o_SPI_Stb = stb;
  assign o_SPI_Clk = sclk;
  assign o_SPI_Dio = dio;

`ifdef TM1638_SPI_DIAG_EN
  logic [3:0] diag_addr;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst)
      diag_addr <= '0;
    else if (state == IDLE && i_Data_Ready && i_Data[16])
      diag_addr <= i_Data[3:0];
  end

  assign o_Diag_State = state;
  assign o_Diag_Data  = word;
  assign o_Diag_Addr  = diag_addr;
`else
  assign o_Diag_State = '0;
  assign o_Diag_Data  = '0;
  assign o_Diag_Addr  = '0;
`endif

endmodule

// File: tb/tb_tm1638_spi.sv
// Scoreboard bench for tm1638_spi: expected bytes, busy lengths and STB frame lengths
// are queued at drive time and compared as the monitor observes the pins.
module tb_tm1638_spi;
  localparam int CYCLES = 4;
`ifdef TM1638_SPI_DIAG_EN
  localparam bit DIAG = 1'b1;
`else
  localparam bit DIAG = 1'b0;
`endif

  logic        i_Rst, i_Clk, i_Data_Ready;
  logic [17:0] i_Data;
  logic        o_Busy, o_SPI_Stb, o_SPI_Clk, o_SPI_Dio;
  logic [2:0]  o_Diag_State;
  logic [17:0] o_Diag_Data;
  logic [3:0]  o_Diag_Addr;

  tm1638_spi #(.CYCLES(CYCLES)) dut (
    .i_Rst(i_Rst), .i_Clk(i_Clk), .o_Busy(o_Busy), .i_Data_Ready(i_Data_Ready),
    .i_Data(i_Data), .o_SPI_Stb(o_SPI_Stb), .o_SPI_Clk(o_SPI_Clk), .o_SPI_Dio(o_SPI_Dio),
    .o_Diag_State(o_Diag_State), .o_Diag_Data(o_Diag_Data), .o_Diag_Addr(o_Diag_Addr)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] exp_byte[$];
  int         exp_busy[$];
  int         exp_stb[$];   // -1: frame length depends on bench idle gaps, not checked
  bit         frame_open = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor state
  int busy_cnt = 0, lo_cnt = 0, stb_lo = 0, stb_hi = 0, last_gap = 0;
  int rises = 0, nbits = 0, stb_rises = 0;
  logic [7:0] shreg = '0;
  logic p_busy = 1'b0, p_clk = 1'b1, p_stb = 1'b1;

  initial begin
    forever begin
      @(negedge i_Clk);
      if (i_Rst) begin
        busy_cnt = 0; lo_cnt = 0; stb_lo = 0; stb_hi = 0; nbits = 0;
        p_busy = 1'b0; p_clk = 1'b1; p_stb = 1'b1;
      end else begin
        if (o_Busy) busy_cnt++;
        else if (p_busy) begin
          if (exp_busy.size() == 0) chk("busy_unexpected", busy_cnt, 0);
          else chk("busy_len", busy_cnt, exp_busy.pop_front());
          busy_cnt = 0;
        end
        if (!o_SPI_Clk) lo_cnt++;
        else if (!p_clk) begin
          chk("clk_lo_len", lo_cnt, CYCLES);
          lo_cnt = 0;
          shreg = {o_SPI_Dio, shreg[7:1]};
          rises++;
          nbits++;
          if (nbits == 8) begin
            if (exp_byte.size() == 0) chk("byte_unexpected", {24'd0, shreg}, 32'hFFFF_FFFF);
            else chk("byte", {24'd0, shreg}, {24'd0, exp_byte.pop_front()});
            nbits = 0;
          end
        end
        if (!o_SPI_Stb) begin
          if (p_stb) begin
            last_gap = stb_hi;
            stb_lo = 0;
          end
          stb_lo++;
        end else begin
          if (!p_stb) begin
            stb_rises++;
            stb_hi = 0;
            if (exp_stb.size() == 0) chk("stb_unexpected", 1, 0);
            else begin
              int e;
              e = exp_stb.pop_front();
              if (e >= 0) chk("stb_low_len", stb_lo, e);
            end
          end
          stb_hi++;
        end
        p_busy = o_Busy; p_clk = o_SPI_Clk; p_stb = o_SPI_Stb;
      end
    end
  end

  task automatic wait_busy(input logic val, input int max);
    int n = 0;
    while (o_Busy !== val && n < max) begin
      @(negedge i_Clk);
      n++;
    end
    chk("wait_busy", o_Busy, val);
  endtask

  // Model of the pin activity one word should produce.
  task automatic push_exp(input logic [17:0] w);
    int b;
    exp_byte.push_back(w[7:0]);
    if (w[16]) exp_byte.push_back(w[15:8]);
    b = 16 * (w[16] ? 2 : 1) + (w[16] ? 1 : 0) + (frame_open ? 0 : 1) + (w[17] ? 0 : 1);
    exp_busy.push_back(b * CYCLES);
    if (!w[17]) exp_stb.push_back(frame_open ? -1 : b * CYCLES);
    frame_open = w[17];
  endtask

  task automatic send(input logic [17:0] w);
    bit was_open;
    wait_busy(1'b0, 400);
    was_open = frame_open;
    push_exp(w);
    i_Data = w;
    i_Data_Ready = 1'b1;
    @(negedge i_Clk);
    i_Data_Ready = 1'b0;
    chk("busy_rise", o_Busy, 1);
    chk("diag_state", o_Diag_State, DIAG ? (was_open ? 3'd2 : 3'd1) : 3'd0);
    chk("diag_data", o_Diag_Data, DIAG ? w : 18'd0);
  endtask

  initial begin
    int r0, n;
    i_Rst = 1'b1; i_Data_Ready = 1'b0; i_Data = '0;
    repeat (3) @(negedge i_Clk);
    chk("rst_stb", o_SPI_Stb, 1);
    chk("rst_clk", o_SPI_Clk, 1);
    chk("rst_dio", o_SPI_Dio, 1);
    chk("rst_busy", o_Busy, 0);
    chk("rst_state", o_Diag_State, 0);
    chk("rst_data", o_Diag_Data, 0);
    chk("rst_addr", o_Diag_Addr, 0);
    i_Rst = 1'b0;
    repeat (2) @(negedge i_Clk);

    // Single byte, then two bytes
    send(18'h00001);
    wait_busy(1'b0, 400);
    chk("idle_stb", o_SPI_Stb, 1);
    chk("idle_clk", o_SPI_Clk, 1);
    chk("idle_dio", o_SPI_Dio, 1);
    send(18'h10105);
    wait_busy(1'b0, 400);
    chk("addr_mode1", o_Diag_Addr, DIAG ? 4'h5 : 4'h0);
    send(18'h000A3);
    wait_busy(1'b0, 400);
    chk("addr_mode0_kept", o_Diag_Addr, DIAG ? 4'h5 : 4'h0);

    // Continued frame: one STB rise across two words
    r0 = stb_rises;
    send(18'h20011);
    wait_busy(1'b0, 400);
    chk("cont_stb_low", o_SPI_Stb, 0);
    send(18'h000C4);
    wait_busy(1'b0, 400);
    chk("cont_stb_rises", stb_rises - r0, 1);

    // Ready and data wiggled mid-transfer must be ignored
    send(18'h0005A);
    repeat (10) @(negedge i_Clk);
    i_Data = 18'h3FFFF; i_Data_Ready = 1'b1;
    repeat (20) @(negedge i_Clk);
    i_Data = 18'h1F0F0;
    repeat (5) @(negedge i_Clk);
    i_Data_Ready = 1'b0;
    wait_busy(1'b0, 400);

    // Ready held high: back-to-back frames with a single STB-high clock
    push_exp(18'h00081);
    push_exp(18'h00081);
    i_Data = 18'h00081; i_Data_Ready = 1'b1;
    wait_busy(1'b1, 10);
    wait_busy(1'b0, 400);
    wait_busy(1'b1, 10);
    i_Data_Ready = 1'b0;
    wait_busy(1'b0, 400);
    chk("b2b_gap", last_gap, 1);

    // Reset during bit 3, then a clean frame
    r0 = rises;
    i_Data = 18'h000FF; i_Data_Ready = 1'b1;
    @(negedge i_Clk);
    i_Data_Ready = 1'b0;
    n = 0;
    while (rises - r0 < 3 && n < 200) begin
      @(negedge i_Clk);
      n++;
    end
    chk("bit3_reached", rises - r0, 3);
    repeat (CYCLES + 1) @(negedge i_Clk);
    #1 i_Rst = 1'b1;
    #1;
    chk("mid_rst_stb", o_SPI_Stb, 1);
    chk("mid_rst_clk", o_SPI_Clk, 1);
    chk("mid_rst_dio", o_SPI_Dio, 1);
    chk("mid_rst_busy", o_Busy, 0);
    chk("mid_rst_state", o_Diag_State, 0);
    repeat (3) @(negedge i_Clk);
    i_Rst = 1'b0;
    frame_open = 1'b0;
    @(negedge i_Clk);
    send(18'h00033);
    wait_busy(1'b0, 400);
    repeat (3) @(negedge i_Clk);

    chk("q_bytes_empty", exp_byte.size(), 0);
    chk("q_busy_empty", exp_busy.size(), 0);
    chk("q_stb_empty", exp_stb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
